sram_port_adapter: RTL

Responder-side front end for one port of the `tc_sram` vector register file. It accepts valid/ready requests from an initiator (vector lane, load/store unit) and issues them on the raw SRAM port protocol (`req`/`we`/`addr`/`wdata`/`be`). It tracks each read through the fixed SRAM `Latency` and returns read data in order through a credit-protected response FIFO with valid/ready backpressure. One instance sits between each initiator and each SRAM port.

---
 rtl/sram_port_adapter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_port_adapter.sv
// sram_port_adapter: responder-side front end for one port of the tc_sram
// vector register file. Accepts valid/ready requests and issues them on the
// raw SRAM port. Reads are tracked through the fixed SRAM latency and are
// returned in order through a credit-protected response FIFO.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o request handshake (ready depends on credits only)
//   req_we_i            1 = write, 0 = read
//   req_addr_i          word address
//   req_wdata_i         write data
//   req_be_i            write byte enables (ignored for reads)
//   rsp_valid_o/ready_i read response handshake
//   rsp_rdata_o         read data (FIFO head)
//   sram_req_o/we_o     SRAM request / write enable (same cycle as accept)
//   sram_addr_o         SRAM address
//   sram_wdata_o/be_o   SRAM write data / byte enables
//   sram_rdata_i        SRAM read data, valid Latency cycles after request
module sram_port_adapter #(
  parameter int unsigned NumWords  = 128,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 4,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CredWidth = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [CredWidth-1:0] CredMax = CredWidth'(RspDepth);
  localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(RspDepth - 1);

  logic [CredWidth-1:0] r_cred;
  logic [CredWidth-1:0] r_count;
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [DataWidth-1:0] r_mem [RspDepth];

  logic w_fire;
  logic w_rd_fire;
  logic w_push;
  logic w_pop;

  // Request side: ready is a function of registered credits only
  assign req_ready_o = !rst_i && (r_cred < CredMax);
  assign w_fire      = req_valid_i && req_ready_o;
  assign w_rd_fire   = w_fire && !req_we_i;

  // SRAM port: payload is zeroed whenever no request is issued
  assign sram_req_o   = w_fire;
  assign sram_we_o    = w_fire && req_we_i;
  assign sram_addr_o  = w_fire ? req_addr_i  : '0;
  assign sram_wdata_o = w_fire ? req_wdata_i : '0;
  assign sram_be_o    = w_fire ? req_be_i    : '0;

  // Response side
  assign rsp_valid_o = (r_count != '0);
  assign rsp_rdata_o = r_mem[r_rptr];
  assign w_pop       = rsp_valid_o && rsp_ready_i;

  // Read tracking: a read's data is pushed when it leaves the latency pipe
  generate
    if (Latency == 0) begin : g_lat0
      assign w_push = w_rd_fire;
    end else begin : g_lat
      logic [Latency-1:0] r_vld;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_vld <= '0;
        end else begin
          r_vld <= (r_vld << 1) | Latency'(w_rd_fire);
        end
      end
      assign w_push = r_vld[Latency-1];
    end
  endgenerate

  // Credits: outstanding reads, in flight plus held in the FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cred <= '0;
    end else begin
      case ({w_rd_fire, w_pop})
        2'b10:   r_cred <= r_cred + CredWidth'(1);
        2'b01:   r_cred <= r_cred - CredWidth'(1);
        default: r_cred <= r_cred;
      endcase
    end
  end

  // Response FIFO: circular buffer, simultaneous push and pop both honoured
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= sram_rdata_i;
        r_wptr        <= (r_wptr == PtrLast) ? '0 : r_wptr + PtrWidth'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + PtrWidth'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CredWidth'(1);
        2'b01:   r_count <= r_count - CredWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credits make a push into a full FIFO unreachable
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_count == CredMax)));

endmodule
